dual_cam_sdram_arb: RTL and testbench

DUAL_CAM_SDRAM_ARB -- requirements
Module: dual_cam_sdram_arb

---
 rtl/dual_cam_sdram_arb.sv | 128 ++++++++++++
 tb/tb_dual_cam_sdram_arb.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/dual_cam_sdram_arb.sv
// Burst arbiter sharing one SDRAM command port between two camera writers and a display reader.
// Optional macro ARB_RD_PRIORITY_EN: reads win outright, writers round-robin among themselves.
module dual_cam_sdram_arb #(
    parameter int BURST_LEN = 512,
    parameter int AW        = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          init_done,
    input  logic          wr0_req,
    input  logic          wr1_req,
    input  logic          rd_req,
    input  logic [AW-1:0] max_addr,
    input  logic [AW-1:0] wr1_base,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic          cmd_write,
    output logic [AW-1:0] cmd_addr,
    output logic [9:0]    cmd_len,
    input  logic          cmd_done,
    output logic [2:0]    gnt
);
    typedef enum logic [1:0] {IDLE, ARB, CMD, BUSY} state_t;

    localparam logic [2:0] GNT_WR0 = 3'b001;
    localparam logic [2:0] GNT_WR1 = 3'b010;
    localparam logic [2:0] GNT_RD  = 3'b100;
    localparam logic [AW:0] STEP   = (AW+1)'(BURST_LEN);

    state_t        state;
    logic [AW-1:0] wr0_addr;
    logic [AW-1:0] wr1_addr;
    logic [AW-1:0] rd_addr;
    logic          wr1_init;
    logic [AW-1:0] wr1_cur;
    logic [AW:0]   wr1_end;
    logic [2:0]    win;
`ifdef ARB_RD_PRIORITY_EN
    logic          last_wr;
`else
    logic [1:0]    last_gnt;
`endif

    assign cmd_len = 10'(BURST_LEN);
    // wr1 start address is taken from wr1_base the first time ARB is visited after reset
    assign wr1_cur = wr1_init ? wr1_base : wr1_addr;
    assign wr1_end = {1'b0, wr1_base} + {1'b0, max_addr};

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr,
                                                input logic [AW-1:0] start,
                                                input logic [AW:0]   stop);
        logic [AW:0] sum;
        sum = {1'b0, addr} + STEP;
        return (sum >= stop) ? start : sum[AW-1:0];
    endfunction

    always_comb begin
        win = 3'b000;
`ifdef ARB_RD_PRIORITY_EN
        if (rd_req)                                  win = GNT_RD;
        else if (wr0_req && (last_wr || !wr1_req))   win = GNT_WR0;
        else if (wr1_req)                            win = GNT_WR1;
`else
        // search order starts just after the last granted port: wr0 -> wr1 -> rd
        case (last_gnt)
            2'd0:    win = wr1_req ? GNT_WR1 : rd_req  ? GNT_RD  : wr0_req ? GNT_WR0 : 3'b000;
            2'd1:    win = rd_req  ? GNT_RD  : wr0_req ? GNT_WR0 : wr1_req ? GNT_WR1 : 3'b000;
            default: win = wr0_req ? GNT_WR0 : wr1_req ? GNT_WR1 : rd_req  ? GNT_RD  : 3'b000;
        endcase
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= 3'b000;
            cmd_valid <= 1'b0;
            cmd_write <= 1'b0;
            cmd_addr  <= '0;
            wr0_addr  <= '0;
            wr1_addr  <= '0;
            rd_addr   <= '0;
            wr1_init  <= 1'b1;
`ifdef ARB_RD_PRIORITY_EN
            last_wr   <= 1'b1;
`else
            last_gnt  <= 2'd2;
`endif
        end else begin
            case (state)
                IDLE: if (init_done) state <= ARB;
                ARB: begin
                    if (wr1_init) begin
                        wr1_addr <= wr1_base;
                        wr1_init <= 1'b0;
                    end
                    if (!init_done) begin
                        state <= IDLE;
                    end else if (win != 3'b000) begin
                        gnt       <= win;
                        cmd_valid <= 1'b1;
                        cmd_write <= !win[2];
                        cmd_addr  <= win[0] ? wr0_addr : (win[1] ? wr1_cur : rd_addr);
                        state     <= CMD;
                    end
                end
                CMD: if (cmd_ready) begin
                    cmd_valid <= 1'b0;
                    state     <= BUSY;
                end
                BUSY: if (cmd_done) begin
                    // cmd_addr still holds this burst's start, so advance from it
                    if (gnt[0]) wr0_addr <= next_addr(cmd_addr, '0, {1'b0, max_addr});
                    if (gnt[1]) wr1_addr <= next_addr(cmd_addr, wr1_base, wr1_end);
                    if (gnt[2]) rd_addr  <= next_addr(cmd_addr, '0, wr1_end);
`ifdef ARB_RD_PRIORITY_EN
                    if (!gnt[2]) last_wr <= gnt[1];
`else
                    last_gnt <= gnt[0] ? 2'd0 : (gnt[1] ? 2'd1 : 2'd2);
`endif
                    gnt   <= 3'b000;
                    state <= init_done ? ARB : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dual_cam_sdram_arb.sv
// Directed bench for dual_cam_sdram_arb; expectations follow the ARB_RD_PRIORITY_EN build setting.
module tb_dual_cam_sdram_arb;
    logic        clk;
    logic        rst_n;
    logic        init_done;
    logic        wr0_req;
    logic        wr1_req;
    logic        rd_req;
    logic [23:0] max_addr;
    logic [23:0] wr1_base;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [23:0] cmd_addr;
    logic [9:0]  cmd_len;
    logic        cmd_done;
    logic [2:0]  gnt;

    int vectors;
    int miscompares;
    int lat;

    dual_cam_sdram_arb #(.BURST_LEN(512), .AW(24)) dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done),
        .wr0_req(wr0_req), .wr1_req(wr1_req), .rd_req(rd_req),
        .max_addr(max_addr), .wr1_base(wr1_base),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_done(cmd_done), .gnt(gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cmd(output int n);
        n = 0;
        while (cmd_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic serve(input logic [2:0] eg, input logic [23:0] ea, input string tag);
        int n;
        wait_cmd(n);
        lat = n;
        check({tag, "_valid"}, 32'(cmd_valid), 32'd1);
        check({tag, "_gnt"},   32'(gnt), 32'(eg));
        check({tag, "_addr"},  32'(cmd_addr), 32'(ea));
        check({tag, "_write"}, 32'(cmd_write), 32'(!eg[2]));
        cmd_ready = 1'b1;
        tick();
        check({tag, "_acc"},   32'(cmd_valid), 32'd0);
        check({tag, "_hold"},  32'(gnt), 32'(eg));
        repeat (4) tick();
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        check({tag, "_clr"},   32'(gnt), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        logic       ok;
        logic [2:0] eg5;
        logic [23:0] ea5;
        int n;
        vectors = 0; miscompares = 0; lat = 0;
        rst_n = 1'b0; init_done = 1'b0; wr0_req = 1'b0; wr1_req = 1'b0; rd_req = 1'b0;
        cmd_ready = 1'b1; cmd_done = 1'b0;
        max_addr = 24'h001000; wr1_base = 24'h002000;
        repeat (3) tick();

        // scenario 1: reset values, then no command before init_done / without requests
        check("rst_valid", 32'(cmd_valid), 32'd0);
        check("rst_write", 32'(cmd_write), 32'd0);
        check("rst_addr",  32'(cmd_addr), 32'd0);
        check("rst_gnt",   32'(gnt), 32'd0);
        check("cmd_len",   32'(cmd_len), 32'd512);
        rst_n = 1'b1;
        wr0_req = 1'b1;
        ok = 1'b1;
        repeat (20) begin
            tick();
            if (cmd_valid !== 1'b0) ok = 1'b0;
        end
        check("s1_no_init", 32'(ok), 32'd1);
        wr0_req = 1'b0;
        init_done = 1'b1;
        ok = 1'b1;
        repeat (10) begin
            tick();
            if (cmd_valid !== 1'b0) ok = 1'b0;
        end
        check("s1_no_req", 32'(ok), 32'd1);

        // scenario 2: wr0/wr1 alternate
        wr0_req = 1'b1; wr1_req = 1'b1;
        serve(3'b001, 24'h000000, "s2_a");
        serve(3'b010, 24'h002000, "s2_b");
        check("s2_latency", 32'(lat <= 1), 32'd1);
        serve(3'b001, 24'h000200, "s2_c");
        wr0_req = 1'b0; wr1_req = 1'b0;

        // scenario 3: wr0 wrap in a 1024-word region
        max_addr = 24'h000400;
        do_reset();
        wr0_req = 1'b1;
        serve(3'b001, 24'h000000, "s3_a");
        serve(3'b001, 24'h000200, "s3_b");
        serve(3'b001, 24'h000000, "s3_wrap");
        wr0_req = 1'b0;

        // scenario 4: all three requesting
        max_addr = 24'h001000;
        do_reset();
        wr0_req = 1'b1; wr1_req = 1'b1; rd_req = 1'b1;
`ifdef ARB_RD_PRIORITY_EN
        serve(3'b100, 24'h000000, "s4_a");
        serve(3'b100, 24'h000200, "s4_b");
        serve(3'b100, 24'h000400, "s4_c");
        serve(3'b100, 24'h000600, "s4_d");
        eg5 = 3'b100; ea5 = 24'h000800;
`else
        serve(3'b001, 24'h000000, "s4_a");
        serve(3'b010, 24'h002000, "s4_b");
        serve(3'b100, 24'h000000, "s4_c");
        serve(3'b001, 24'h000200, "s4_d");
        eg5 = 3'b010; ea5 = 24'h002200;
`endif

        // scenario 5: stall in CMD with toggling requests and a stray cmd_done
        cmd_ready = 1'b0;
        wait_cmd(n);
        check("s5_valid", 32'(cmd_valid), 32'd1);
        check("s5_gnt",   32'(gnt), 32'(eg5));
        check("s5_addr",  32'(cmd_addr), 32'(ea5));
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wr0_req = i[0]; wr1_req = !i[0]; rd_req = i[1];
            cmd_done = (i == 3);
            tick();
            if (cmd_valid !== 1'b1 || gnt !== eg5 || cmd_addr !== ea5) ok = 1'b0;
        end
        cmd_done = 1'b0;
        check("s5_stable", 32'(ok), 32'd1);
        cmd_ready = 1'b1;
        tick();
        check("s5_acc", 32'(cmd_valid), 32'd0);

        // scenario 6: asynchronous reset in BUSY
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_valid", 32'(cmd_valid), 32'd0);
        check("s6_gnt",   32'(gnt), 32'd0);
        check("s6_addr",  32'(cmd_addr), 32'd0);
        tick();
        rst_n = 1'b1;
        wr0_req = 1'b1; wr1_req = 1'b0; rd_req = 1'b0;
        serve(3'b001, 24'h000000, "s6_wr0");
        wr0_req = 1'b0;

        // scenario 7: wr1 wrap
        max_addr = 24'h000400;
        do_reset();
        wr1_req = 1'b1;
        serve(3'b010, 24'h002000, "s7_a");
        serve(3'b010, 24'h002200, "s7_b");
        serve(3'b010, 24'h002000, "s7_wrap");
        wr1_req = 1'b0;

        // scenario 8: init_done drop during a read burst, then rd wrap
        wr1_base = 24'h000200; max_addr = 24'h000200;
        do_reset();
        rd_req = 1'b1;
        wait_cmd(n);
        check("s8_a_gnt",  32'(gnt), 32'b100);
        check("s8_a_addr", 32'(cmd_addr), 32'd0);
        tick();
        init_done = 1'b0;
        repeat (3) tick();
        check("s8_busy_hold", 32'(gnt), 32'b100);
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        ok = 1'b1;
        repeat (6) begin
            tick();
            if (cmd_valid !== 1'b0) ok = 1'b0;
        end
        check("s8_idle", 32'(ok), 32'd1);
        init_done = 1'b1;
        serve(3'b100, 24'h000200, "s8_resume");
        serve(3'b100, 24'h000000, "s8_wrap");
        rd_req = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
